mem_access: RTL

// Memory-access stage; consumes the execution stage's result bundle (distinct/valid strobe plus controls).

---
 rtl/core_pkg.sv | 58 +++++
 rtl/branch_resolve.sv | 42 ++++
 rtl/mem_access.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the memory-access stage: FSM states, branch and
// writeback-source codes, and the latched control bundle.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD_WAIT,
        ST_UART_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_J    = 2'b01,
        BR_JR   = 2'b10,
        BR_NONE = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        WB_RESULT = 2'b00,
        WB_MEM    = 2'b01,
        WB_LINK   = 2'b10,
        WB_ALT    = 2'b11
    } wb_src_t;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_STORE,
        OP_LOAD,
        OP_UART
    } op_t;

    typedef struct packed {
        logic    aorf;
        logic    reg_write;
        wb_src_t mem_to_reg;
        branch_t branch;
        op_t     op;
    } ctrl_t;

    // UART read wins over store, store wins over load
    function automatic op_t op_select(
        input logic uart,
        input logic mem_write,
        input logic mem_read
    );
        if (uart)
            return OP_UART;
        else if (mem_write)
            return OP_STORE;
        else if (mem_read)
            return OP_LOAD;
        else
            return OP_ALU;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution for the memory-access stage.
// Produces the redirect decision and target pc.
module branch_resolve
    import core_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 5
) (
    input  branch_t                   branch,
    input  logic [31:0]               result,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    input  logic [INST_MEM_WIDTH-1:0] inst_index,
    output logic                      taken,
    output logic [INST_MEM_WIDTH-1:0] target
);

    logic unused_hi;
    assign unused_hi = ^result[31:INST_MEM_WIDTH];

    always_comb begin
        taken  = 1'b0;
        target = '0;
        unique case (branch)
            BR_COND: begin
                taken  = result[0];
                target = pc2;
            end
            BR_J: begin
                taken  = 1'b1;
                target = inst_index;
            end
            BR_JR: begin
                taken  = 1'b1;
                target = result[INST_MEM_WIDTH-1:0];
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: data-memory load/store, UART receive read,
// branch resolution and a single writeback beat per instruction.
module mem_access
    import core_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 5,
    parameter int DATA_MEM_WIDTH = 10,
    parameter int DMEM_LATENCY   = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  logic                      valid,
    input  logic                      AorF,
    input  logic                      RegWrite,
    input  logic [1:0]                MemtoReg,
    input  logic [1:0]                Branch,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic                      UARTtoReg,
    input  logic [31:0]               register_data,
    input  logic [31:0]               result,
    input  logic [4:0]                rdist,
    input  logic [25:0]               inst_index,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    output logic                      dmem_en,
    output logic                      dmem_we,
    output logic [DATA_MEM_WIDTH-1:0] dmem_addr,
    output logic [31:0]               dmem_wdata,
    input  logic [31:0]               dmem_rdata,
    input  logic                      uart_rvalid,
    input  logic [7:0]                uart_rdata,
    output logic                      uart_rready,
    output logic                      busy,
    output logic                      wb_valid,
    output logic                      wb_RegWrite,
    output logic                      wb_AorF,
    output logic [4:0]                wb_rdist,
    output logic [31:0]               wb_data,
    output logic                      branch_taken,
    output logic [INST_MEM_WIDTH-1:0] branch_target
);

    localparam int CW = $clog2(DMEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_LATENCY);

    state_t                    state_q;
    state_t                    state_d;
    ctrl_t                     ctrl_q;
    logic [31:0]               result_q;
    logic [31:0]               store_q;
    logic [31:0]               rdata_q;
    logic [4:0]                rdist_q;
    logic [INST_MEM_WIDTH-1:0] pc1_q;
    logic [INST_MEM_WIDTH-1:0] pc2_q;
    logic [INST_MEM_WIDTH-1:0] jidx_q;
    logic [CW-1:0]             cnt_q;
    logic                      accept;
    logic                      done;
    logic                      taken;
    logic [INST_MEM_WIDTH-1:0] target;
    logic                      unused_idx;

    assign unused_idx = ^inst_index[25:INST_MEM_WIDTH];

    assign accept = distinct && valid && (state_q == ST_IDLE);
    assign done   = (state_q == ST_DONE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            result_q <= '0;
            store_q  <= '0;
            rdata_q  <= '0;
            rdist_q  <= '0;
            pc1_q    <= '0;
            pc2_q    <= '0;
            jidx_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ctrl_q.aorf       <= AorF;
                ctrl_q.reg_write  <= RegWrite;
                ctrl_q.mem_to_reg <= wb_src_t'(MemtoReg);
                ctrl_q.branch     <= branch_t'(Branch);
                ctrl_q.op         <= op_select(UARTtoReg, MemWrite, MemRead);
                result_q <= result;
                store_q  <= register_data;
                rdist_q  <= rdist;
                pc1_q    <= pc1;
                pc2_q    <= pc2;
                jidx_q   <= inst_index[INST_MEM_WIDTH-1:0];
                cnt_q    <= '0;
            end
            // cnt_q == 0 is the issue cycle; data lands DMEM_LATENCY later
            if (state_q == ST_LOAD_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_LAST)
                    rdata_q <= dmem_rdata;
            end
            if (state_q == ST_UART_WAIT && uart_rvalid)
                rdata_q <= {24'b0, uart_rdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        dmem_en     = 1'b0;
        dmem_we     = 1'b0;
        uart_rready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op_select(UARTtoReg, MemWrite, MemRead))
                        OP_UART:  state_d = ST_UART_WAIT;
                        OP_STORE: state_d = ST_STORE;
                        OP_LOAD:  state_d = ST_LOAD_WAIT;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_STORE: begin
                dmem_en = 1'b1;
                dmem_we = 1'b1;
                state_d = ST_DONE;
            end
            ST_LOAD_WAIT: begin
                dmem_en = (cnt_q == '0);
                if (cnt_q == CNT_LAST)
                    state_d = ST_DONE;
            end
            ST_UART_WAIT: begin
                uart_rready = 1'b1;
                if (uart_rvalid)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    branch_resolve #(
        .INST_MEM_WIDTH(INST_MEM_WIDTH)
    ) u_branch (
        .branch    (ctrl_q.branch),
        .result    (result_q),
        .pc2       (pc2_q),
        .inst_index(jidx_q),
        .taken     (taken),
        .target    (target)
    );

    always_comb begin
        wb_data = '0;
        if (done) begin
            if (ctrl_q.op == OP_UART) begin
                wb_data = rdata_q;
            end else begin
                unique case (ctrl_q.mem_to_reg)
                    WB_MEM:  wb_data = rdata_q;
                    WB_LINK: wb_data = {{(32-INST_MEM_WIDTH){1'b0}}, pc1_q};
                    default: wb_data = result_q;
                endcase
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign wb_valid      = done;
    assign wb_RegWrite   = done && ctrl_q.reg_write;
    assign wb_AorF       = done && ctrl_q.aorf;
    assign wb_rdist      = done ? rdist_q : 5'd0;
    assign branch_taken  = done && taken;
    assign branch_target = (done && taken) ? target : '0;
    assign dmem_addr     = result_q[DATA_MEM_WIDTH-1:0];
    assign dmem_wdata    = store_q;

endmodule
